// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the 1:N stream demultiplexer.
package demux_stream_pkg;

  localparam int MAX_CH    = 64;
  localparam int MAX_SEL_W = $clog2(MAX_CH);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Decoded load vector; an out-of-range select decodes to all zeros.
  function automatic logic [MAX_CH-1:0] ch_onehot(input logic [MAX_SEL_W-1:0] sel, input int n);
    logic [MAX_CH-1:0] vec;
    vec = '0;
    if (int'(sel) < n) vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice for a single demux channel.
module demux_out_slot import demux_stream_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  slot_state_e state;

  // A load while full only happens when the consumer is draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state    <= SLOT_FULL;
            out_data <= load_data;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            out_data <= load_data;
          end else if (out_ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign out_valid = (state == SLOT_FULL);
  assign free      = ~out_valid | out_ready;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1:N valid/ready stream demultiplexer with per-channel output slots.
// Optional broadcast input enabled by defining DEMUX_BCAST_EN.
module demux_stream_1ton import demux_stream_pkg::*; #(
  parameter  int NUM_CH = 16,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     drop
);

  logic [NUM_CH-1:0] sel_dec;
  logic [NUM_CH-1:0] slot_load;
  logic [NUM_CH-1:0] slot_free;
  logic              sel_in_range;
  logic              single_ready;
  logic              is_bcast;
  logic              accept;

  // Only non-power-of-two channel counts can see an out-of-range select.
  generate
    if (NUM_CH == (1 << SEL_W)) begin : g_pow2
      assign sel_in_range = 1'b1;
    end else begin : g_npow2
      assign sel_in_range = (in_sel < SEL_W'(NUM_CH));
    end
  endgenerate

`ifdef DEMUX_BCAST_EN
  assign is_bcast = in_bcast;
`else
  assign is_bcast = 1'b0;
`endif

  always_comb begin
    sel_dec = NUM_CH'(ch_onehot(MAX_SEL_W'(in_sel), NUM_CH));
  end

  assign single_ready = sel_in_range ? |(sel_dec & slot_free) : 1'b1;
  assign in_ready     = is_bcast ? &slot_free : single_ready;
  assign accept       = in_valid & in_ready;

  always_comb begin
    slot_load = '0;
    if (accept) slot_load = is_bcast ? {NUM_CH{1'b1}} : sel_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop <= 1'b0;
    else        drop <= accept & ~is_bcast & ~sel_in_range;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W]),
      .free      (slot_free[k])
    );
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Self-checking bench for demux_stream_1ton: a 16-channel and a 10-channel instance
// checked against queue-based per-channel reference models.
`timescale 1ns/1ps
module tb_demux_stream_1ton;

  localparam int NA = 16;
  localparam int NB = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic             a_in_valid, a_in_ready, a_drop;
  logic [3:0]       a_in_sel;
  logic [DW-1:0]    a_in_data;
  logic [NA-1:0]    a_out_valid, a_out_ready;
  logic [NA*DW-1:0] a_out_data;

  logic             b_in_valid, b_in_ready, b_drop;
  logic [3:0]       b_in_sel;
  logic [DW-1:0]    b_in_data;
  logic [NB-1:0]    b_out_valid, b_out_ready;
  logic [NB*DW-1:0] b_out_data;

`ifdef DEMUX_BCAST_EN
  logic a_in_bcast, b_in_bcast;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: each channel is a queue of words waiting for its consumer.
  logic [DW-1:0] qa[NA][$];
  logic [DW-1:0] qb[NB][$];
  logic exp_drop_a, exp_drop_b;
  logic last_acc_a, last_acc_b;

  always #5 clk = ~clk;

  demux_stream_1ton #(.NUM_CH(NA), .DATA_W(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast(a_in_bcast),
`endif
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .drop(a_drop)
  );

  demux_stream_1ton #(.NUM_CH(NB), .DATA_W(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast(b_in_bcast),
`endif
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .drop(b_drop)
  );

  function automatic bit bcast_a();
`ifdef DEMUX_BCAST_EN
    return a_in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit bcast_b();
`ifdef DEMUX_BCAST_EN
    return b_in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  // A channel can take a word if nothing is waiting or its consumer takes it now.
  function automatic bit exp_ready_a();
    if (bcast_a()) begin
      for (int k = 0; k < NA; k++) if (qa[k].size() != 0 && !a_out_ready[k]) return 1'b0;
      return 1'b1;
    end
    if (int'(a_in_sel) >= NA) return 1'b1;
    return qa[a_in_sel].size() == 0 || a_out_ready[a_in_sel];
  endfunction

  function automatic bit exp_ready_b();
    if (bcast_b()) begin
      for (int k = 0; k < NB; k++) if (qb[k].size() != 0 && !b_out_ready[k]) return 1'b0;
      return 1'b1;
    end
    if (int'(b_in_sel) >= NB) return 1'b1;
    return qb[b_in_sel].size() == 0 || b_out_ready[b_in_sel];
  endfunction

  function automatic logic [NA-1:0] exp_valid_a();
    logic [NA-1:0] v;
    for (int k = 0; k < NA; k++) v[k] = (qa[k].size() != 0);
    return v;
  endfunction

  function automatic logic [NB-1:0] exp_valid_b();
    logic [NB-1:0] v;
    for (int k = 0; k < NB; k++) v[k] = (qb[k].size() != 0);
    return v;
  endfunction

  function automatic logic [NA*DW-1:0] exp_data_a();
    logic [NA*DW-1:0] d;
    d = '0;
    for (int k = 0; k < NA; k++) if (qa[k].size() != 0) d[k*DW +: DW] = qa[k][0];
    return d;
  endfunction

  function automatic logic [NB*DW-1:0] exp_data_b();
    logic [NB*DW-1:0] d;
    d = '0;
    for (int k = 0; k < NB; k++) if (qb[k].size() != 0) d[k*DW +: DW] = qb[k][0];
    return d;
  endfunction

  function automatic logic [NA*DW-1:0] mask_a(input logic [NA-1:0] v);
    logic [NA*DW-1:0] m;
    for (int k = 0; k < NA; k++) m[k*DW +: DW] = {DW{v[k]}};
    return m;
  endfunction

  function automatic logic [NB*DW-1:0] mask_b(input logic [NB-1:0] v);
    logic [NB*DW-1:0] m;
    for (int k = 0; k < NB; k++) m[k*DW +: DW] = {DW{v[k]}};
    return m;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NA; k++) qa[k].delete();
    for (int k = 0; k < NB; k++) qb[k].delete();
    exp_drop_a = 1'b0;
    exp_drop_b = 1'b0;
    last_acc_a = 1'b0;
    last_acc_b = 1'b0;
  endtask

  // One clock: consumers pop, then the accepted word (if any) is appended.
  task automatic step();
    bit acc_a, acc_b;
    acc_a = a_in_valid && exp_ready_a();
    acc_b = b_in_valid && exp_ready_b();
    @(posedge clk);
    for (int k = 0; k < NA; k++) if (qa[k].size() != 0 && a_out_ready[k]) void'(qa[k].pop_front());
    for (int k = 0; k < NB; k++) if (qb[k].size() != 0 && b_out_ready[k]) void'(qb[k].pop_front());
    if (acc_a) begin
      if (bcast_a()) for (int k = 0; k < NA; k++) qa[k].push_back(a_in_data);
      else if (int'(a_in_sel) < NA) qa[a_in_sel].push_back(a_in_data);
    end
    if (acc_b) begin
      if (bcast_b()) for (int k = 0; k < NB; k++) qb[k].push_back(b_in_data);
      else if (int'(b_in_sel) < NB) qb[b_in_sel].push_back(b_in_data);
    end
    exp_drop_a = acc_a && !bcast_a() && int'(a_in_sel) >= NA;
    exp_drop_b = acc_b && !bcast_b() && int'(b_in_sel) >= NB;
    last_acc_a = acc_a;
    last_acc_b = acc_b;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0;
    b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
`ifdef DEMUX_BCAST_EN
    a_in_bcast = 1'b0; b_in_bcast = 1'b0;
`endif
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (a_out_valid !== '0) begin n_miss++; $display("[TB] FAIL reset_valid_a: got %h expected %h", a_out_valid, 16'h0); end
    n_vec++; if (a_out_data !== '0) begin n_miss++; $display("[TB] FAIL reset_data_a: got %h expected 0", a_out_data); end
    n_vec++; if (a_drop !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_drop_a: got %b expected 0", a_drop); end
    n_vec++; if (b_out_valid !== '0 || b_drop !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_b: valid %h drop %b expected 0 0", b_out_valid, b_drop); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 4'(1 + 3 * i);
      a_in_data  = 8'($urandom);
      #1;
      n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_fill_ready: got %b expected 1", a_in_ready); end
      step();
    end
    a_in_valid = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 16'h0092) begin n_miss++; $display("[TB] FAIL reset_fill_valid: got %h expected %h", a_out_valid, 16'h0092); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== '0) begin n_miss++; $display("[TB] FAIL async_reset_valid: got %h expected 0", a_out_valid); end
    n_vec++; if (a_out_data !== '0) begin n_miss++; $display("[TB] FAIL async_reset_data: got %h expected 0", a_out_data); end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_routing();
    logic [DW-1:0] expd;
    a_out_ready = '1;
    for (int k = 0; k < NA; k++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 4'(k);
      a_in_data  = 8'hA0 + 8'(k);
      #1;
      n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL route_ready sel=%0d: got %b expected 1", k, a_in_ready); end
      if (k > 0) begin
        expd = 8'hA0 + 8'(k - 1);
        n_vec++; if (a_out_valid !== (16'h1 << (k - 1))) begin n_miss++; $display("[TB] FAIL route_valid ch=%0d: got %h expected %h", k - 1, a_out_valid, 16'h1 << (k - 1)); end
        n_vec++; if (a_out_data[(k-1)*DW +: DW] !== expd) begin n_miss++; $display("[TB] FAIL route_data ch=%0d: got %h expected %h", k - 1, a_out_data[(k-1)*DW +: DW], expd); end
      end
      step();
    end
    a_in_valid = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 16'h8000 || a_out_data[15*DW +: DW] !== 8'hAF) begin n_miss++; $display("[TB] FAIL route_last: valid %h data %h expected 8000 af", a_out_valid, a_out_data[15*DW +: DW]); end
    step();
    #1;
    n_vec++; if (a_out_valid !== '0) begin n_miss++; $display("[TB] FAIL route_empty: got %h expected 0", a_out_valid); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    a_out_ready = '1;
    a_out_ready[5] = 1'b0;
    a_in_valid = 1'b1; a_in_sel = 4'd5; a_in_data = 8'h51;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_first_ready: got %b expected 1", a_in_ready); end
    step();
    a_in_data = 8'h52;
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_second_blocked: got %b expected 0", a_in_ready); end
    n_vec++; if (a_out_valid[5] !== 1'b1 || a_out_data[5*DW +: DW] !== 8'h51) begin n_miss++; $display("[TB] FAIL bp_held: valid %b data %h expected 1 51", a_out_valid[5], a_out_data[5*DW +: DW]); end
    step();
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_still_blocked: got %b expected 0", a_in_ready); end
    a_in_sel = 4'd6; a_in_data = 8'h61;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_other_ready: got %b expected 1", a_in_ready); end
    step();
    a_in_sel = 4'd5; a_in_data = 8'h52;
    #1;
    n_vec++; if (a_out_valid[6] !== 1'b1 || a_out_data[6*DW +: DW] !== 8'h61) begin n_miss++; $display("[TB] FAIL bp_other_delivered: valid %b data %h expected 1 61", a_out_valid[6], a_out_data[6*DW +: DW]); end
    n_vec++; if (a_out_data[5*DW +: DW] !== 8'h51 || a_in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_ch5_hold: data %h ready %b expected 51 0", a_out_data[5*DW +: DW], a_in_ready); end
    a_out_ready[5] = 1'b1;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_release_ready: got %b expected 1", a_in_ready); end
    step();
    a_in_valid = 1'b0;
    #1;
    n_vec++; if (a_out_valid[5] !== 1'b1 || a_out_data[5*DW +: DW] !== 8'h52) begin n_miss++; $display("[TB] FAIL bp_second_delivered: valid %b data %h expected 1 52", a_out_valid[5], a_out_data[5*DW +: DW]); end
    step();
    #1;
    n_vec++; if (a_out_valid !== exp_valid_a()) begin n_miss++; $display("[TB] FAIL bp_drained: got %h expected %h", a_out_valid, exp_valid_a()); end
    @(negedge clk);
  endtask

  task automatic test_drain_refill();
    a_out_ready = '0;
    a_in_valid = 1'b1; a_in_sel = 4'd3; a_in_data = 8'h33;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL dr_load_ready: got %b expected 1", a_in_ready); end
    step();
    a_out_ready[3] = 1'b1;
    a_in_data = 8'h34;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL dr_refill_ready: got %b expected 1", a_in_ready); end
    step();
    a_in_valid = 1'b0;
    #1;
    n_vec++; if (a_out_valid[3] !== 1'b1 || a_out_data[3*DW +: DW] !== 8'h34) begin n_miss++; $display("[TB] FAIL dr_new_data: valid %b data %h expected 1 34", a_out_valid[3], a_out_data[3*DW +: DW]); end
    step();
    #1;
    n_vec++; if (a_out_valid[3] !== 1'b0) begin n_miss++; $display("[TB] FAIL dr_empty: got %b expected 0", a_out_valid[3]); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    b_out_ready = '0;
    b_in_valid = 1'b1; b_in_sel = 4'd2; b_in_data = 8'h22;
    #1;
    n_vec++; if (b_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL oor_pre_ready: got %b expected 1", b_in_ready); end
    step();
    b_in_sel = 4'd12; b_in_data = 8'h55;
    #1;
    n_vec++; if (b_in_ready !== 1'b1 || b_drop !== 1'b0) begin n_miss++; $display("[TB] FAIL oor_ready: ready %b drop %b expected 1 0", b_in_ready, b_drop); end
    step();
    b_in_valid = 1'b0;
    #1;
    n_vec++; if (b_drop !== 1'b1) begin n_miss++; $display("[TB] FAIL oor_drop_pulse: got %b expected 1", b_drop); end
    n_vec++; if (b_out_valid !== 10'h004) begin n_miss++; $display("[TB] FAIL oor_valid_unchanged: got %h expected %h", b_out_valid, 10'h004); end
    step();
    #1;
    n_vec++; if (b_drop !== 1'b0) begin n_miss++; $display("[TB] FAIL oor_drop_clear: got %b expected 0", b_drop); end
    n_vec++; if (b_out_valid !== 10'h004 || b_out_data[2*DW +: DW] !== 8'h22) begin n_miss++; $display("[TB] FAIL oor_ch2_hold: valid %h data %h expected 004 22", b_out_valid, b_out_data[2*DW +: DW]); end
    b_out_ready = '1;
    step();
  endtask

`ifdef DEMUX_BCAST_EN
  task automatic test_bcast();
    a_out_ready = '1;
    a_out_ready[9] = 1'b0;
    a_in_valid = 1'b1; a_in_bcast = 1'b0; a_in_sel = 4'd9; a_in_data = 8'h99;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bc_stall_load: got %b expected 1", a_in_ready); end
    step();
    a_in_bcast = 1'b1; a_in_sel = 4'd0; a_in_data = 8'h3C;
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL bc_blocked: got %b expected 0", a_in_ready); end
    step();
    a_out_ready[9] = 1'b1;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bc_release: got %b expected 1", a_in_ready); end
    step();
    a_in_valid = 1'b0; a_in_bcast = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== '1) begin n_miss++; $display("[TB] FAIL bc_all_valid: got %h expected ffff", a_out_valid); end
    n_vec++; if (a_out_data !== {NA{8'h3C}}) begin n_miss++; $display("[TB] FAIL bc_all_data: got %h expected all 3c", a_out_data); end
    step();
    b_out_ready = '1;
    b_in_valid = 1'b1; b_in_bcast = 1'b1; b_in_sel = 4'd12; b_in_data = 8'h3C;
    #1;
    n_vec++; if (b_in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bc_b_ready: got %b expected 1", b_in_ready); end
    step();
    b_in_valid = 1'b0; b_in_bcast = 1'b0;
    #1;
    n_vec++; if (b_drop !== 1'b0 || b_out_valid !== '1) begin n_miss++; $display("[TB] FAIL bc_no_drop: drop %b valid %h expected 0 3ff", b_drop, b_out_valid); end
    step();
  endtask
`endif

  task automatic test_random();
    logic [NA-1:0]    eva;
    logic [NB-1:0]    evb;
    logic [NA*DW-1:0] eda;
    logic [NB*DW-1:0] edb;
    last_acc_a = 1'b0;
    last_acc_b = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      // A presented word stays put until it is taken.
      if (!a_in_valid || last_acc_a) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_in_sel   = 4'($urandom_range(0, 15));
        a_in_data  = 8'($urandom);
`ifdef DEMUX_BCAST_EN
        a_in_bcast = ($urandom_range(0, 7) == 0);
`endif
      end
      if (!b_in_valid || last_acc_b) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_sel   = 4'($urandom_range(0, 15));
        b_in_data  = 8'($urandom);
`ifdef DEMUX_BCAST_EN
        b_in_bcast = ($urandom_range(0, 7) == 0);
`endif
      end
      a_out_ready = NA'($urandom());
      b_out_ready = NB'($urandom());
      #1;
      eva = exp_valid_a(); eda = exp_data_a();
      evb = exp_valid_b(); edb = exp_data_b();
      if (a_in_valid) begin
        n_vec++; if (a_in_ready !== exp_ready_a()) begin n_miss++; $display("[TB] FAIL rnd_ready_a cyc=%0d: got %b expected %b", c, a_in_ready, exp_ready_a()); end
      end
      if (b_in_valid) begin
        n_vec++; if (b_in_ready !== exp_ready_b()) begin n_miss++; $display("[TB] FAIL rnd_ready_b cyc=%0d: got %b expected %b", c, b_in_ready, exp_ready_b()); end
      end
      n_vec++; if (a_out_valid !== eva) begin n_miss++; $display("[TB] FAIL rnd_valid_a cyc=%0d: got %h expected %h", c, a_out_valid, eva); end
      n_vec++; if ((a_out_data & mask_a(eva)) !== eda) begin n_miss++; $display("[TB] FAIL rnd_data_a cyc=%0d: got %h expected %h", c, a_out_data & mask_a(eva), eda); end
      n_vec++; if (b_out_valid !== evb) begin n_miss++; $display("[TB] FAIL rnd_valid_b cyc=%0d: got %h expected %h", c, b_out_valid, evb); end
      n_vec++; if ((b_out_data & mask_b(evb)) !== edb) begin n_miss++; $display("[TB] FAIL rnd_data_b cyc=%0d: got %h expected %h", c, b_out_data & mask_b(evb), edb); end
      n_vec++; if (a_drop !== exp_drop_a || b_drop !== exp_drop_b) begin n_miss++; $display("[TB] FAIL rnd_drop cyc=%0d: got %b%b expected %b%b", c, a_drop, b_drop, exp_drop_a, exp_drop_b); end
      step();
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_routing();
    test_backpressure();
    test_drain_refill();
    test_out_of_range();
`ifdef DEMUX_BCAST_EN
    test_bcast();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
